vector_alu_pipe: RTL and testbench
==================================

// Module: vector_alu_pipe
// PURPOSE
//  Pipelined, lane-masked SIMD integer ALU for the shader core execute stage: VECTOR_SIZE lanes of
//  DATA_WIDTH, registered output with valid/ready flow control, tag passthrough and illegal-op flag.
//  Keeps the legacy 5-bit opcode map and adds shifts, signed min/max and set-less-than.
// PARAMETERS
//  DATA_WIDTH   32  lane width in bits (>=8)
//  VECTOR_SIZE  4   number of lanes (>=1)
//  PIPE_STAGES  2   register stages from accept to o_valid (>=1)
//  TAG_WIDTH    4   width of sideband tag carried with each op (>=1)
// PORTS
//  i_clk        in   1                     clock, all state on rising edge
//  i_rst        in   1                     synchronous reset, active-high
//  i_valid      in   1                     upstream op valid
//  o_ready      out  1                     ALU can accept an op this cycle
//  i_operand_a  in   VECTOR_SIZE*DATA_WIDTH  packed [lane][bit] operand A
//  i_operand_b  in   VECTOR_SIZE*DATA_WIDTH  packed [lane][bit] operand B
//  i_opcode     in   5                     operation select
//  i_lane_mask  in   VECTOR_SIZE           1 = lane active, 0 = lane result forced to 0
//  i_tag        in   TAG_WIDTH             sideband id, returned unchanged with result
//  o_valid      out  1                     result valid
//  i_ready      in   1                     downstream accepts result
//  o_result     out  VECTOR_SIZE*DATA_WIDTH  packed lane results
//  o_tag        out  TAG_WIDTH             tag of op in o_result
//  o_illegal    out  1                     op had undefined opcode (o_result all 0)
//  o_busy       out  1                     any pipeline stage holds a valid op
// BEHAVIOUR
//  Clock/reset: one clock i_clk; i_rst synchronous, active-high.
//  Reset: all stage valid bits 0; o_valid=0, o_busy=0, o_result=0, o_tag=0, o_illegal=0; o_ready=1
//    the cycle after reset deasserts. Reset mid-operation discards all in-flight ops, no output.
//  Handshake: op accepted when i_valid&o_ready; result consumed when o_valid&i_ready.
//    o_ready = ~o_valid | i_ready (global stall: whole pipe advances together or holds).
//    While o_valid&~i_ready, o_result/o_tag/o_illegal stay stable; no stage changes.
//    Bubbles do not collapse: pipe is a fixed-length shift register gated by the advance enable.
//  Latency: op accepted at edge N appears with o_valid=1 after edge N+PIPE_STAGES-1 (o_ready
//    held), i.e. PIPE_STAGES cycles accept-to-valid; throughput 1 op/cycle with i_ready=1.
//  Compute: combinational per-lane in stage 1; later stages are pure delay registers.
//  Opcodes (per lane, a,b = lane operands, results truncated to DATA_WIDTH):
//    00001 ADD a+b wrap | 00010 SUB a-b wrap | 00011 MUL low DATA_WIDTH bits of a*b
//    00100 SLL a<<sh | 00101 SRL a>>sh logical | 00110 SRA a>>>sh, sh=b[$clog2(DATA_WIDTH)-1:0]
//    01001 AND | 01010 OR | 01011 XOR
//    01100 MIN signed | 01101 MAX signed | 01110 SLT signed: 1 if a<b else 0
//    10001 PASS A | 10010 PASS B | any other: all lanes 0, o_illegal=1 for that op
//  Mask: masked lanes output 0 regardless of opcode; mask does not affect o_illegal.
//  o_busy = OR of all stage valid bits (includes output stage).
// TESTING
//  1 Reset: assert i_rst 2 cycles with i_valid=1 -> o_valid=0,o_result=0,o_busy=0; o_ready=1 after.
//  2 Latency/throughput (PIPE_STAGES=2, 32b x4): ADD a=lane{1,2,3,0xFFFFFFFF}, b=lane{1,1,1,1},
//    tag 5, i_ready=1 -> 2 cycles later o_result={2,3,4,0} (wrap), o_tag=5; 8 back-to-back ops
//    -> 8 consecutive o_valid cycles, in order.
//  3 New ops: SRA a=0x80000000 b=4 -> 0xF8000000; SRL same -> 0x08000000; MIN a=-1 b=3 -> -1;
//    MAX -> 3; SLT a=-1 b=3 -> 1; MUL 0x10000*0x10000 -> 0.
//  4 Backpressure: stream ops, drop i_ready for 3 cycles -> o_ready=0, o_result/o_tag held, no op
//    lost or duplicated; resume -> order preserved; i_valid&i_ready same cycle as full pipe works.
//  5 Mask/illegal: mask=4'b0101 ADD -> lanes 1,3 = 0; opcode 00111 -> all lanes 0, o_illegal=1.
//  6 Reset with 2 ops in flight -> next cycle o_valid=0, o_busy=0; neither op ever emerges.

Source files
------------

// File: rtl/vector_alu_pipe.sv
// ---------------------------------------------------------------------------
// vector_alu_pipe
//
// Purpose:
//   Lane-masked SIMD integer ALU for the shader execute stage. VECTOR_SIZE
//   lanes of DATA_WIDTH bits are computed combinationally from the inputs.
//   The results then travel through PIPE_STAGES registers to the output,
//   using valid/ready flow control. A sideband tag is carried with each op.
//   Opcodes that are not defined raise an illegal flag.
//
// Ports:
//   i_clk        clock; all state changes on the rising edge
//   i_rst        synchronous reset, active-high
//   i_valid      upstream op valid
//   o_ready      ALU can accept an op this cycle
//   i_operand_a  packed [lane][bit] operand A
//   i_operand_b  packed [lane][bit] operand B
//   i_opcode     5-bit operation select (legacy map plus shifts/min/max/slt)
//   i_lane_mask  1 = lane active, 0 = lane result forced to 0
//   i_tag        sideband id, returned unchanged with the result
//   o_valid      result valid
//   i_ready      downstream accepts the result
//   o_result     packed lane results
//   o_tag        tag of the op in o_result
//   o_illegal    op had an undefined opcode (o_result is all zero)
//   o_busy       some pipeline stage holds a valid op
// ---------------------------------------------------------------------------
module vector_alu_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int VECTOR_SIZE = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] i_operand_a,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] i_operand_b,
  input  logic [4:0]                        i_opcode,
  input  logic [VECTOR_SIZE-1:0]            i_lane_mask,
  input  logic [TAG_WIDTH-1:0]              i_tag,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] o_result,
  output logic [TAG_WIDTH-1:0]              o_tag,
  output logic                              o_illegal,
  output logic                              o_busy
);

  localparam int VW  = VECTOR_SIZE * DATA_WIDTH;
  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_MUL = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRL = 5'b00101;
  localparam logic [4:0] OP_SRA = 5'b00110;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_XOR = 5'b01011;
  localparam logic [4:0] OP_MIN = 5'b01100;
  localparam logic [4:0] OP_MAX = 5'b01101;
  localparam logic [4:0] OP_SLT = 5'b01110;
  localparam logic [4:0] OP_PSA = 5'b10001;
  localparam logic [4:0] OP_PSB = 5'b10010;

  logic [VW-1:0]        stg_result [PIPE_STAGES];
  logic [TAG_WIDTH-1:0] stg_tag    [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] stg_valid;
  logic [PIPE_STAGES-1:0] stg_illegal;

  logic          advance;
  logic [VW-1:0] s1_result;
  logic          s1_illegal;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_SLL, OP_SRL, OP_SRA,
      OP_AND, OP_OR, OP_XOR, OP_MIN, OP_MAX, OP_SLT,
      OP_PSA, OP_PSB: op_legal = 1'b1;
      default:        op_legal = 1'b0;
    endcase
  endfunction

  // An undefined opcode falls through to zero, so illegal ops need no
  // separate zeroing path.
  function automatic logic [DATA_WIDTH-1:0] lane_alu(
    input logic [4:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [SHW-1:0] sh;
    logic           lt_s;
    sh       = b[SHW-1:0];
    lt_s     = $signed(a) < $signed(b);
    lane_alu = '0;
    case (op)
      OP_ADD: lane_alu = a + b;
      OP_SUB: lane_alu = a - b;
      OP_MUL: lane_alu = a * b;
      OP_SLL: lane_alu = a << sh;
      OP_SRL: lane_alu = a >> sh;
      OP_SRA: lane_alu = $unsigned($signed(a) >>> sh);
      OP_AND: lane_alu = a & b;
      OP_OR:  lane_alu = a | b;
      OP_XOR: lane_alu = a ^ b;
      OP_MIN: lane_alu = lt_s ? a : b;
      OP_MAX: lane_alu = lt_s ? b : a;
      OP_SLT: lane_alu = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      OP_PSA: lane_alu = a;
      OP_PSB: lane_alu = b;
      default: lane_alu = '0;
    endcase
  endfunction

  always_comb begin
    s1_illegal = ~op_legal(i_opcode);
    s1_result  = '0;
    for (int l = 0; l < VECTOR_SIZE; l++) begin
      if (i_lane_mask[l]) begin
        s1_result[l*DATA_WIDTH +: DATA_WIDTH] =
          lane_alu(i_opcode,
                   i_operand_a[l*DATA_WIDTH +: DATA_WIDTH],
                   i_operand_b[l*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  // Global stall: the pipe moves only as a whole. It holds while the
  // output slot is occupied and not taken. Bubbles are kept, not collapsed,
  // so latency stays fixed.
  assign advance = ~stg_valid[PIPE_STAGES-1] | i_ready;
  assign o_ready = advance;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stg_valid   <= '0;
      stg_illegal <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stg_result[k] <= '0;
        stg_tag[k]    <= '0;
      end
    end else if (advance) begin
      // A bubble loads zeros. Outputs then read as zero whenever
      // o_valid is low.
      stg_valid[0]   <= i_valid;
      stg_illegal[0] <= i_valid & s1_illegal;
      stg_result[0]  <= i_valid ? s1_result : '0;
      stg_tag[0]     <= i_valid ? i_tag : '0;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        stg_valid[k]   <= stg_valid[k-1];
        stg_illegal[k] <= stg_illegal[k-1];
        stg_result[k]  <= stg_result[k-1];
        stg_tag[k]     <= stg_tag[k-1];
      end
    end
  end

  assign o_valid   = stg_valid[PIPE_STAGES-1];
  assign o_illegal = stg_illegal[PIPE_STAGES-1];
  assign o_result  = stg_result[PIPE_STAGES-1];
  assign o_tag     = stg_tag[PIPE_STAGES-1];
  assign o_busy    = |stg_valid;

endmodule

// File: tb/tb_vector_alu_pipe.sv
module tb_vector_alu_pipe;
  localparam int DW = 32;
  localparam int VS = 4;
  localparam int PS = 2;
  localparam int TW = 4;
  localparam int VW = VS * DW;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [VW-1:0] i_operand_a = '0;
  logic [VW-1:0] i_operand_b = '0;
  logic [4:0]    i_opcode = 5'b00001;
  logic [VS-1:0] i_lane_mask = '1;
  logic [TW-1:0] i_tag = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [VW-1:0] o_result;
  logic [TW-1:0] o_tag;
  logic          o_illegal;
  logic          o_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [VW-1:0] res;
    logic [TW-1:0] tag;
    logic          ill;
  } exp_t;

  exp_t sb_q[$];

  logic [4:0] legal_ops [14] = '{5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                                 5'b00110, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
                                 5'b01101, 5'b01110, 5'b10001, 5'b10010};

  vector_alu_pipe #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .PIPE_STAGES(PS), .TAG_WIDTH(TW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_operand_a(i_operand_a), .i_operand_b(i_operand_b), .i_opcode(i_opcode),
    .i_lane_mask(i_lane_mask), .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_tag(o_tag), .o_illegal(o_illegal), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference lane semantics in plain 32-bit integer arithmetic.
  function automatic logic [31:0] ref_lane(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    int          sa, sb;
    int unsigned sh;
    logic [63:0] p;
    sa = a;
    sb = b;
    sh = b % 32;
    p  = {32'b0, a} * {32'b0, b};
    case (op)
      5'b00001: return a + b;
      5'b00010: return a - b;
      5'b00011: return p[31:0];
      5'b00100: return a << sh;
      5'b00101: return a >> sh;
      5'b00110: return sa >>> sh;
      5'b01001: return a & b;
      5'b01010: return a | b;
      5'b01011: return a ^ b;
      5'b01100: return (sa < sb) ? a : b;
      5'b01101: return (sa > sb) ? a : b;
      5'b01110: return (sa < sb) ? 32'd1 : 32'd0;
      5'b10001: return a;
      5'b10010: return b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic exp_t model(input logic [4:0] op, input logic [VW-1:0] a,
                                 input logic [VW-1:0] b, input logic [VS-1:0] mask,
                                 input logic [TW-1:0] tag);
    exp_t e;
    e.res = '0;
    for (int l = 0; l < VS; l++)
      if (mask[l]) e.res[l*DW +: DW] = ref_lane(op, a[l*DW +: DW], b[l*DW +: DW]);
    e.tag = tag;
    e.ill = 1'b1;
    for (int i = 0; i < 14; i++)
      if (legal_ops[i] == op) e.ill = 1'b0;
    return e;
  endfunction

  // Scoreboard: holds every op accepted but not yet consumed, in order.
  always @(negedge i_clk) begin
    if (i_rst) begin
      sb_q.delete();
    end else begin
      chk("ready_rule", o_ready, !o_valid || i_ready);
      chk("busy", o_busy, sb_q.size() != 0);
      if (sb_q.size() == 0) begin
        chk("no_spurious_valid", o_valid, 1'b0);
      end else if (o_valid) begin
        chk("sb_result", o_result, sb_q[0].res);
        chk("sb_tag", o_tag, sb_q[0].tag);
        chk("sb_illegal", o_illegal, sb_q[0].ill);
        if (i_ready) void'(sb_q.pop_front());
      end
      if (i_valid && o_ready)
        sb_q.push_back(model(i_opcode, i_operand_a, i_operand_b, i_lane_mask, i_tag));
    end
  end

  function automatic logic [31:0] rnd_word();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_random(input logic [TW-1:0] tag);
    for (int l = 0; l < VS; l++) begin
      i_operand_a[l*DW +: DW] = rnd_word();
      i_operand_b[l*DW +: DW] = rnd_word();
    end
    if ($urandom % 8 == 0) i_opcode = 5'($urandom);
    else i_opcode = legal_ops[$urandom_range(13, 0)];
    i_lane_mask = 4'($urandom);
    i_tag = tag;
  endtask

  // One op into an empty pipe, with exact latency and literal results.
  task automatic single(input string name, input logic [4:0] op, input logic [VW-1:0] a,
                        input logic [VW-1:0] b, input logic [VS-1:0] mask,
                        input logic [TW-1:0] tag, input logic [VW-1:0] exp_res,
                        input logic exp_ill);
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_opcode = op; i_operand_a = a; i_operand_b = b;
    i_lane_mask = mask; i_tag = tag; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    chk({name, "_not_early"}, o_valid, 1'b0);
    @(posedge i_clk);
    @(negedge i_clk);
    chk({name, "_valid"}, o_valid, 1'b1);
    chk({name, "_result"}, o_result, exp_res);
    chk({name, "_tag"}, o_tag, tag);
    chk({name, "_illegal"}, o_illegal, exp_ill);
  endtask

  task automatic drain();
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 20 && (sb_q.size() != 0 || o_busy); c++) @(posedge i_clk);
    @(negedge i_clk);
    chk("drain_empty", sb_q.size(), 0);
  endtask

  function automatic logic [VW-1:0] splat(input logic [31:0] w);
    return {w, w, w, w};
  endfunction

  logic [VW-1:0] va, vb, held_res;
  logic [TW-1:0] held_tag;

  initial begin
    // Reset held for two edges with a valid op presented.
    i_rst = 1'b1; i_valid = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_result", o_result, '0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_tag", o_tag, '0);
    chk("rst_illegal", o_illegal, 1'b0);
    i_rst = 1'b0; i_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready_after", o_ready, 1'b1);

    va = {32'hFFFF_FFFF, 32'd3, 32'd2, 32'd1};
    vb = {32'd1, 32'd1, 32'd1, 32'd1};
    single("add_wrap", 5'b00001, va, vb, 4'b1111, 4'd5, {32'd0, 32'd4, 32'd3, 32'd2}, 1'b0);
    single("sra", 5'b00110, splat(32'h8000_0000), splat(32'd4), 4'b1111, 4'd1,
           splat(32'hF800_0000), 1'b0);
    single("srl", 5'b00101, splat(32'h8000_0000), splat(32'd4), 4'b1111, 4'd2,
           splat(32'h0800_0000), 1'b0);
    single("min", 5'b01100, splat(32'hFFFF_FFFF), splat(32'd3), 4'b1111, 4'd3,
           splat(32'hFFFF_FFFF), 1'b0);
    single("max", 5'b01101, splat(32'hFFFF_FFFF), splat(32'd3), 4'b1111, 4'd4,
           splat(32'd3), 1'b0);
    single("slt", 5'b01110, splat(32'hFFFF_FFFF), splat(32'd3), 4'b1111, 4'd6,
           splat(32'd1), 1'b0);
    single("mul", 5'b00011, splat(32'h0001_0000), splat(32'h0001_0000), 4'b1111, 4'd7,
           splat(32'd0), 1'b0);
    single("mask", 5'b00001, va, vb, 4'b0101, 4'd8, {32'd0, 32'd4, 32'd0, 32'd2}, 1'b0);
    single("illegal", 5'b00111, va, vb, 4'b1111, 4'd9, '0, 1'b1);

    // Eight back-to-back ops: eight consecutive valid cycles, in order.
    for (int c = 0; c <= 10; c++) begin
      @(posedge i_clk); #1;
      i_ready = 1'b1;
      if (c < 8) begin
        i_valid = 1'b1;
        drive_random(4'(c));
      end else begin
        i_valid = 1'b0;
      end
      @(negedge i_clk);
      if (c >= 2 && c <= 9) begin
        chk("b2b_valid", o_valid, 1'b1);
        chk("b2b_tag", o_tag, 4'(c - 2));
      end
      if (c == 10) chk("b2b_end", o_valid, 1'b0);
    end
    drain();

    // Stream with a three-cycle downstream stall.
    for (int c = 0; c < 14; c++) begin
      @(posedge i_clk); #1;
      i_valid = 1'b1;
      drive_random(4'(c));
      i_ready = !(c >= 4 && c <= 6);
      @(negedge i_clk);
      if (c >= 4 && c <= 6) begin
        chk("stall_ready", o_ready, 1'b0);
        if (c == 4) begin
          held_res = o_result;
          held_tag = o_tag;
        end else begin
          chk("stall_hold_res", o_result, held_res);
          chk("stall_hold_tag", o_tag, held_tag);
        end
      end
    end
    drain();

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      @(posedge i_clk); #1;
      i_valid = ($urandom % 4) != 0;
      i_ready = ($urandom % 4) != 0;
      drive_random(4'($urandom));
    end
    drain();

    // Reset with two ops in flight: neither may ever emerge.
    @(posedge i_clk); #1;
    i_valid = 1'b1; drive_random(4'hA); i_ready = 1'b0;
    @(posedge i_clk); #1;
    drive_random(4'hB);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("inflight_busy", o_busy, 1'b1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    chk("midrst_valid", o_valid, 1'b0);
    chk("midrst_busy", o_busy, 1'b0);
    for (int c = 0; c < 6; c++) @(posedge i_clk);
    @(negedge i_clk);
    chk("midrst_quiet", o_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
